dma_mem_port_arb: RTL and testbench
===================================

Name: dma_mem_port_arb

Overview:
Two-requester arbiter sharing one Avalon-MM master port into descriptor memory. Requester 0 is the descriptor fetch engine, which issues 8-beat burst reads. Requester 1 is the descriptor writeback engine, which issues single-beat status writes. The arbiter grants one requester at a time using round-robin priority. It locks the port until a granted read burst has fully returned, so a writeback can never interleave with a descriptor read that is still in flight.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports
BCOUNT_W, 4, burstcount width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_read_i  in  1  fetch read request, held until accepted
fetch_bcount_i  in  BCOUNT_W  fetch burst length
fetch_addr_i  in  ADDR_W  fetch burst address
fetch_waitrequest_o  out  1  fetch stall
fetch_rddata_o  out  DATA_W  read data to fetch
fetch_readdatavalid_o  out  1  read beat valid to fetch
wb_write_i  in  1  writeback write request, held until accepted
wb_addr_i  in  ADDR_W  writeback address
wb_wrdata_i  in  DATA_W  writeback data
wb_waitrequest_o  out  1  writeback stall
avm_read_o  out  1  master read
avm_write_o  out  1  master write
avm_addr_o  out  ADDR_W  master address
avm_bcount_o  out  BCOUNT_W  master burstcount
avm_wrdata_o  out  DATA_W  master write data
avm_waitrequest_i  in  1  slave stall
avm_rddata_i  in  DATA_W  slave read data
avm_readdatavalid_i  in  1  slave read beat valid
err_unexp_rdv_o  out  1  sticky flag: read beat arrived with no burst outstanding

Behaviour:
- States: IDLE, FETCH_CMD, FETCH_DATA, WB_CMD. Encoding is in the package. Reset forces IDLE.
- Reset values:
  - avm_read_o, avm_write_o, fetch_readdatavalid_o, err_unexp_rdv_o = 0.
  - fetch_waitrequest_o, wb_waitrequest_o = 1.
  - avm_addr_o, avm_bcount_o, avm_wrdata_o = 0.
- IDLE:
  - Both waitrequests are 1 and no master command is driven.
  - Arbitration is registered, so one cycle passes from a request seen in IDLE to the command appearing on the master.
  - Only fetch_read_i: go to FETCH_CMD.
  - Only wb_write_i: go to WB_CMD.
  - Both: grant the requester that was not granted last. last_grant resets to writeback, so fetch wins the first tie. last_grant updates on each grant.
- FETCH_CMD:
  - avm_read_o = fetch_read_i; addr and bcount pass through combinationally.
  - fetch_waitrequest_o = avm_waitrequest_i; wb_waitrequest_o = 1.
  - On fetch_read_i & ~avm_waitrequest_i: latch burst length into exp_beats (bcount 0 is latched as 1), clear the beat counter, go to FETCH_DATA.
- FETCH_DATA:
  - No command is driven; both waitrequests are 1.
  - Each avm_readdatavalid_i increments the beat counter.
  - When the beat that makes the count equal exp_beats arrives, go to IDLE in that same cycle.
- WB_CMD:
  - avm_write_o = wb_write_i; addr and wrdata pass through; avm_bcount_o = 1.
  - wb_waitrequest_o = avm_waitrequest_i; fetch_waitrequest_o = 1.
  - On wb_write_i & ~avm_waitrequest_i: go to IDLE. Writes have no response phase.
- Read data path:
  - fetch_rddata_o = avm_rddata_i always.
  - fetch_readdatavalid_o = avm_readdatavalid_i only in FETCH_CMD (same-cycle beat) or FETCH_DATA, and 0 otherwise.
  - A beat in FETCH_CMD counts toward the burst.
- Stray read beats: avm_readdatavalid_i in IDLE or WB_CMD is dropped and sets err_unexp_rdv_o, which stays set until reset.
- Request dropped before acceptance: if the granted request deasserts before acceptance (protocol violation), return to IDLE next cycle and issue no command.
- Write during a burst: a writeback request arriving during FETCH_CMD/FETCH_DATA stalls until the burst completes and is then granted, even if fetch also re-requests (round-robin).
- Reset mid-burst: return to IDLE and clear counters and last_grant. Only beats arriving after reset flag an error.
- Beat counter is BCOUNT_W+1 bits wide, so no wrap-around is possible at the maximum bcount.

Decomposition:
- dma_pkg holds the state localparams, default widths and the burst length constant (8).
- Sub-module dma_rr_arb2: 2-way round-robin grant with a last_grant register. Inputs: req[1:0], update. Output: one-hot grant.

Test Plan:
- Fetch alone: addr 0x1000, bcount 8, avm_waitrequest low. Required: avm_read_o high 1 cycle after request; 8 fetch_readdatavalid_o beats; return to IDLE on beat 8.
- Writeback alone: addr 0x2004, data 0xDEADBEEF, waitrequest high for 3 cycles. Required: avm_write_o held 4 cycles; wb_waitrequest_o mirrors the slave.
- Simultaneous fetch and writeback requests out of reset. Required: order fetch, writeback, fetch. Writeback is never granted during FETCH_DATA.
- Writeback request arrives at beat 3 of a burst. Required: wb_waitrequest_o stays 1 until beat 8 arrives; write is issued 1 cycle after IDLE.
- readdatavalid pulse in IDLE. Required: fetch_readdatavalid_o = 0 and err_unexp_rdv_o = 1, held until reset.
- Reset asserted during FETCH_DATA at beat 4. Required: all outputs at reset values next cycle; a new fetch completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared constants for the descriptor-memory port arbiter.
//   - default port widths
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - nominal descriptor fetch burst length
package dma_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int BCOUNT_W_DEF    = 4;
  localparam int FETCH_BURST_LEN = 8;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FETCH_CMD  = 2'd1;
  localparam logic [1:0] ST_FETCH_DATA = 2'd2;
  localparam logic [1:0] ST_WB_CMD     = 2'd3;

  // Bit positions in the request/grant vectors.
  localparam int REQ_FETCH = 0;
  localparam int REQ_WB    = 1;

endpackage

// File: rtl/dma_rr_arb2.sv
// dma_rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req[1:0]    - bit 0 fetch, bit 1 writeback
//   update      - record the current grant as the most recent winner
//   grant[1:0]  - one-hot grant (zero when nothing requests)
module dma_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // 0: fetch won last, 1: writeback won last. Resets to writeback so
  // fetch wins the first tie.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update && (grant != 2'b00)) begin
      last_grant_d = grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dma_mem_port_arb.sv
// dma_mem_port_arb: shares one Avalon-MM master port into descriptor memory
// between the descriptor fetch engine (burst reads) and the writeback engine
// (single-beat writes). The port stays locked until a granted read burst has
// fully returned.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   fetch_*                    - fetch requester slave side (read bursts)
//   wb_*                       - writeback requester slave side (writes)
//   avm_*                      - shared master port
//   err_unexp_rdv_o            - sticky: read beat seen with no burst open
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_IDLE       | no owner; registered round-robin arbitration
// ST_FETCH_CMD  | fetch owns port, read command presented to slave
// ST_FETCH_DATA | read accepted, counting returning beats
// ST_WB_CMD     | writeback owns port, write command presented to slave
module dma_mem_port_arb
  import dma_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BCOUNT_W = BCOUNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_read_i,
  input  logic [BCOUNT_W-1:0] fetch_bcount_i,
  input  logic [ADDR_W-1:0]   fetch_addr_i,
  output logic                fetch_waitrequest_o,
  output logic [DATA_W-1:0]   fetch_rddata_o,
  output logic                fetch_readdatavalid_o,
  input  logic                wb_write_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0]   wb_wrdata_i,
  output logic                wb_waitrequest_o,
  output logic                avm_read_o,
  output logic                avm_write_o,
  output logic [ADDR_W-1:0]   avm_addr_o,
  output logic [BCOUNT_W-1:0] avm_bcount_o,
  output logic [DATA_W-1:0]   avm_wrdata_o,
  input  logic                avm_waitrequest_i,
  input  logic [DATA_W-1:0]   avm_rddata_i,
  input  logic                avm_readdatavalid_i,
  output logic                err_unexp_rdv_o
);

  localparam logic [BCOUNT_W:0]   BEAT_ONE = {{BCOUNT_W{1'b0}}, 1'b1};
  localparam logic [BCOUNT_W-1:0] BC_ONE   = {{(BCOUNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  // One bit wider than burstcount so the maximum burst cannot wrap.
  logic [BCOUNT_W:0] beat_cnt_q, beat_cnt_d;
  logic [BCOUNT_W:0] exp_beats_q, exp_beats_d;
  logic              err_q, err_d;

  logic [1:0] grant;
  logic       arb_update;

  dma_rr_arb2 u_rr_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({wb_write_i, fetch_read_i}),
    .update (arb_update),
    .grant  (grant)
  );

  assign fetch_rddata_o  = avm_rddata_i;
  assign err_unexp_rdv_o = err_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    exp_beats_d = exp_beats_q;
    err_d       = err_q;
    arb_update  = 1'b0;

    avm_read_o            = 1'b0;
    avm_write_o           = 1'b0;
    avm_addr_o            = '0;
    avm_bcount_o          = '0;
    avm_wrdata_o          = '0;
    fetch_waitrequest_o   = 1'b1;
    wb_waitrequest_o      = 1'b1;
    fetch_readdatavalid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        arb_update = fetch_read_i | wb_write_i;
        if (grant[REQ_FETCH]) begin
          state_d = ST_FETCH_CMD;
        end else if (grant[REQ_WB]) begin
          state_d = ST_WB_CMD;
        end
        if (avm_readdatavalid_i) begin
          err_d = 1'b1;
        end
      end

      ST_FETCH_CMD: begin
        avm_read_o            = fetch_read_i;
        avm_addr_o            = fetch_addr_i;
        avm_bcount_o          = fetch_bcount_i;
        fetch_waitrequest_o   = avm_waitrequest_i;
        fetch_readdatavalid_o = avm_readdatavalid_i;
        if (!fetch_read_i) begin
          state_d = ST_IDLE;
        end else if (!avm_waitrequest_i) begin
          // A zero burstcount is treated as a single beat.
          exp_beats_d = (fetch_bcount_i == '0) ? BEAT_ONE : {1'b0, fetch_bcount_i};
          beat_cnt_d  = avm_readdatavalid_i ? BEAT_ONE : '0;
          // A same-cycle beat can already finish a one-beat burst.
          state_d     = (avm_readdatavalid_i && (exp_beats_d == BEAT_ONE)) ? ST_IDLE
                                                                          : ST_FETCH_DATA;
        end
      end

      ST_FETCH_DATA: begin
        fetch_readdatavalid_o = avm_readdatavalid_i;
        if (avm_readdatavalid_i) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          if (beat_cnt_d == exp_beats_q) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WB_CMD: begin
        avm_write_o      = wb_write_i;
        avm_addr_o       = wb_addr_i;
        avm_wrdata_o     = wb_wrdata_i;
        avm_bcount_o     = BC_ONE;
        wb_waitrequest_o = avm_waitrequest_i;
        if (avm_readdatavalid_i) begin
          err_d = 1'b1;
        end
        // Writes have no response phase; a dropped request also releases.
        if (!wb_write_i || !avm_waitrequest_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      exp_beats_q <= exp_beats_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_mem_port_arb.sv
// tb_dma_mem_port_arb: scoreboard bench for dma_mem_port_arb.
// Expected master commands are queued by the stimulus in grant order and
// read beats are queued by the slave model as it drives them; a negedge
// monitor pops and compares both.
module tb_dma_mem_port_arb;
  import dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_read_i;
  logic [3:0]  fetch_bcount_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_waitrequest_o;
  logic [31:0] fetch_rddata_o;
  logic        fetch_readdatavalid_o;
  logic        wb_write_i;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_wrdata_i;
  logic        wb_waitrequest_o;
  logic        avm_read_o;
  logic        avm_write_o;
  logic [31:0] avm_addr_o;
  logic [3:0]  avm_bcount_o;
  logic [31:0] avm_wrdata_o;
  logic        avm_waitrequest_i;
  logic [31:0] avm_rddata_i;
  logic        avm_readdatavalid_i;
  logic        err_unexp_rdv_o;

  always #5 clk = ~clk;

  dma_mem_port_arb dut (
    .clk                   (clk),
    .reset                 (reset),
    .fetch_read_i          (fetch_read_i),
    .fetch_bcount_i        (fetch_bcount_i),
    .fetch_addr_i          (fetch_addr_i),
    .fetch_waitrequest_o   (fetch_waitrequest_o),
    .fetch_rddata_o        (fetch_rddata_o),
    .fetch_readdatavalid_o (fetch_readdatavalid_o),
    .wb_write_i            (wb_write_i),
    .wb_addr_i             (wb_addr_i),
    .wb_wrdata_i           (wb_wrdata_i),
    .wb_waitrequest_o      (wb_waitrequest_o),
    .avm_read_o            (avm_read_o),
    .avm_write_o           (avm_write_o),
    .avm_addr_o            (avm_addr_o),
    .avm_bcount_o          (avm_bcount_o),
    .avm_wrdata_o          (avm_wrdata_o),
    .avm_waitrequest_i     (avm_waitrequest_i),
    .avm_rddata_i          (avm_rddata_i),
    .avm_readdatavalid_i   (avm_readdatavalid_i),
    .err_unexp_rdv_o       (err_unexp_rdv_o)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  bc;
    logic [31:0] data;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [31:0] rd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        inject_stray = 1'b0;
  logic        slave_hold   = 1'b0;
  logic        slave_flush  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic wr, input logic [31:0] a,
                                  input logic [3:0] bc, input logic [31:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.bc = bc; c.data = d;
    return c;
  endfunction

  task automatic tick_in();
    @(posedge clk);
    #1;
  endtask

  // Slave: returns max(bcount,1) beats starting the cycle after acceptance.
  initial begin
    int pending;
    int acc;
    pending = 0;
    avm_readdatavalid_i = 1'b0;
    avm_rddata_i = '0;
    forever begin
      @(negedge clk);
      acc = 0;
      if (!reset && avm_read_o && !avm_waitrequest_i)
        acc = (avm_bcount_o == 4'd0) ? 1 : int'(avm_bcount_o);
      @(posedge clk);
      #1;
      pending += acc;
      if (slave_flush) pending = 0;
      avm_readdatavalid_i = 1'b0;
      if (inject_stray) begin
        avm_rddata_i = $urandom;
        avm_readdatavalid_i = 1'b1;
      end else if (pending > 0 && !slave_hold) begin
        avm_rddata_i = $urandom;
        avm_readdatavalid_i = 1'b1;
        rd_q.push_back(avm_rddata_i);
        pending--;
      end
    end
  end

  // Monitor: command and read-data scoreboard, no write while a burst is open.
  cmd_t mon_e;
  int   burst_left = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        burst_left = 0;
      end else begin
        if (burst_left > 0) check_eq("no_wr_in_burst", avm_write_o, 1'b0);
        if ((avm_read_o || avm_write_o) && !avm_waitrequest_i) begin
          check_eq("cmd_pending", cmd_q.size() > 0, 1'b1);
          if (cmd_q.size() > 0) begin
            mon_e = cmd_q.pop_front();
            check_eq("cmd_kind", avm_write_o, mon_e.wr);
            check_eq("cmd_addr", avm_addr_o, mon_e.addr);
            check_eq("cmd_bcount", avm_bcount_o, mon_e.bc);
            if (mon_e.wr) check_eq("cmd_wrdata", avm_wrdata_o, mon_e.data);
          end
          if (avm_read_o) burst_left = (avm_bcount_o == 4'd0) ? 1 : int'(avm_bcount_o);
        end
        if (fetch_readdatavalid_o) begin
          check_eq("rd_pending", rd_q.size() > 0, 1'b1);
          if (rd_q.size() > 0) check_eq("rd_data", fetch_rddata_o, rd_q.pop_front());
          if (burst_left > 0) burst_left--;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_read"}, avm_read_o, 1'b0);
    check_eq({tag, "_write"}, avm_write_o, 1'b0);
    check_eq({tag, "_frdv"}, fetch_readdatavalid_o, 1'b0);
    check_eq({tag, "_err"}, err_unexp_rdv_o, 1'b0);
    check_eq({tag, "_fwait"}, fetch_waitrequest_o, 1'b1);
    check_eq({tag, "_wbwait"}, wb_waitrequest_o, 1'b1);
    check_eq({tag, "_addr"}, avm_addr_o, 32'h0);
    check_eq({tag, "_bcount"}, avm_bcount_o, 4'h0);
    check_eq({tag, "_wrdata"}, avm_wrdata_o, 32'h0);
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic fetch_req(input logic [31:0] a, input logic [3:0] bc);
    int t;
    t = 0;
    fetch_read_i = 1'b1; fetch_addr_i = a; fetch_bcount_i = bc;
    do begin
      @(negedge clk);
      t++;
    end while (fetch_waitrequest_o && t < 200);
    if (fetch_waitrequest_o) check_eq("fetch_accept_timeout", fetch_waitrequest_o, 1'b0);
    tick_in();
    fetch_read_i = 1'b0;
  endtask

  task automatic wb_req(input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    wb_write_i = 1'b1; wb_addr_i = a; wb_wrdata_i = d;
    do begin
      @(negedge clk);
      t++;
    end while (wb_waitrequest_o && t < 200);
    if (wb_waitrequest_o) check_eq("wb_accept_timeout", wb_waitrequest_o, 1'b0);
    tick_in();
    wb_write_i = 1'b0;
  endtask

  // Counts beats delivered to fetch; returns at the negedge of the last one.
  task automatic wait_beats(input int n);
    int got;
    int t;
    got = 0; t = 0;
    while (got < n && t < 100) begin
      @(negedge clk);
      t++;
      if (fetch_readdatavalid_o) got++;
    end
    check_eq("burst_beats", got, n);
  endtask

  // Right after the final beat: one IDLE cycle, then the write on the master.
  task automatic wb_after_burst(input logic [31:0] a, input logic [31:0] d);
    cmd_q.push_back(mk_cmd(1'b1, a, 4'd1, d));
    tick_in();
    wb_write_i = 1'b1; wb_addr_i = a; wb_wrdata_i = d;
    @(negedge clk);
    check_eq("post_burst_idle", avm_write_o, 1'b0);
    @(negedge clk);
    check_eq("post_burst_write", avm_write_o, 1'b1);
    check_eq("post_burst_wbwait", wb_waitrequest_o, 1'b0);
    tick_in();
    wb_write_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    reset = 1'b1;
    fetch_read_i = 1'b0; fetch_bcount_i = '0; fetch_addr_i = '0;
    wb_write_i = 1'b0; wb_addr_i = '0; wb_wrdata_i = '0;
    avm_waitrequest_i = 1'b0;

    repeat (2) tick_in();
    @(negedge clk);
    check_reset_vals("rst");
    tick_in();
    reset = 1'b0;

    // Simultaneous requests out of reset: fetch, writeback, fetch.
    cmd_q.push_back(mk_cmd(1'b0, 32'h100, 4'(FETCH_BURST_LEN), 32'h0));
    cmd_q.push_back(mk_cmd(1'b1, 32'h3000, 4'd1, 32'h11112222));
    cmd_q.push_back(mk_cmd(1'b0, 32'h180, 4'(FETCH_BURST_LEN), 32'h0));
    fork
      begin
        fetch_req(32'h100, 4'(FETCH_BURST_LEN));
        fetch_req(32'h180, 4'(FETCH_BURST_LEN));
      end
      wb_req(32'h3000, 32'h11112222);
    join
    wait_beats(FETCH_BURST_LEN);
    check_eq("rr_cmds_done", cmd_q.size(), 0);

    // Fetch alone: command one cycle after the request, 8 beats, then IDLE.
    tick_in();
    cmd_q.push_back(mk_cmd(1'b0, 32'h1000, 4'(FETCH_BURST_LEN), 32'h0));
    fork
      fetch_req(32'h1000, 4'(FETCH_BURST_LEN));
      begin
        @(negedge clk);
        check_eq("fetch_lat_idle", avm_read_o, 1'b0);
        @(negedge clk);
        check_eq("fetch_lat_cmd", avm_read_o, 1'b1);
      end
    join
    wait_beats(FETCH_BURST_LEN);
    wb_after_burst(32'h2000_0040, 32'h55AA55AA);

    // Burstcount boundaries: 0 behaves as one beat, 15 is the maximum.
    cmd_q.push_back(mk_cmd(1'b0, 32'h1100, 4'd0, 32'h0));
    fetch_req(32'h1100, 4'd0);
    wait_beats(1);
    wb_after_burst(32'h2000_0044, 32'h0BADF00D);
    cmd_q.push_back(mk_cmd(1'b0, 32'h1200, 4'd15, 32'h0));
    fetch_req(32'h1200, 4'd15);
    wait_beats(15);
    wb_after_burst(32'h2000_0048, 32'h13579BDF);

    // Writeback alone with slave waitrequest high for 3 cycles.
    cmd_q.push_back(mk_cmd(1'b1, 32'h2004, 4'd1, 32'hDEADBEEF));
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        wb_write_i = 1'b1; wb_addr_i = 32'h2004; wb_wrdata_i = 32'hDEADBEEF;
      end
      if (i == 5) wb_write_i = 1'b0;
      avm_waitrequest_i = (i >= 1 && i <= 3);
      @(negedge clk);
      check_eq("wb_write_held", avm_write_o, (i >= 1 && i <= 4));
      check_eq("wb_wait_mirror", wb_waitrequest_o, (i != 4));
      check_eq("wb_fetch_wait", fetch_waitrequest_o, 1'b1);
      tick_in();
    end
    avm_waitrequest_i = 1'b0;

    // Writeback request at beat 3 of a burst waits for beat 8.
    cmd_q.push_back(mk_cmd(1'b0, 32'h4000, 4'(FETCH_BURST_LEN), 32'h0));
    cmd_q.push_back(mk_cmd(1'b1, 32'h4100, 4'd1, 32'hCAFEF00D));
    fetch_req(32'h4000, 4'(FETCH_BURST_LEN));
    n = 0; t = 0;
    while (n < 3 && t < 50) begin
      @(negedge clk);
      t++;
      if (fetch_readdatavalid_o) n++;
    end
    tick_in();
    wb_write_i = 1'b1; wb_addr_i = 32'h4100; wb_wrdata_i = 32'hCAFEF00D;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      check_eq("midburst_wb_stall", wb_waitrequest_o, 1'b1);
      check_eq("midburst_no_write", avm_write_o, 1'b0);
      if (fetch_readdatavalid_o) n++;
    end while (n < FETCH_BURST_LEN && t < 50);
    check_eq("midburst_beats", n, FETCH_BURST_LEN);
    @(negedge clk);
    check_eq("midburst_idle_gap", avm_write_o, 1'b0);
    @(negedge clk);
    check_eq("midburst_write", avm_write_o, 1'b1);
    check_eq("midburst_wb_go", wb_waitrequest_o, 1'b0);
    tick_in();
    wb_write_i = 1'b0;

    // Stray read beat in IDLE: dropped, sticky error.
    @(negedge clk);
    inject_stray = 1'b1;
    @(negedge clk);
    inject_stray = 1'b0;
    check_eq("stray_blocked", fetch_readdatavalid_o, 1'b0);
    @(negedge clk);
    check_eq("stray_err_set", err_unexp_rdv_o, 1'b1);
    tick_in();
    cmd_q.push_back(mk_cmd(1'b1, 32'h2100, 4'd1, 32'h0F0F0F0F));
    wb_req(32'h2100, 32'h0F0F0F0F);
    repeat (3) @(negedge clk);
    check_eq("stray_err_held", err_unexp_rdv_o, 1'b1);

    // Reset at beat 4 of a burst.
    tick_in();
    cmd_q.push_back(mk_cmd(1'b0, 32'h5000, 4'(FETCH_BURST_LEN), 32'h0));
    fetch_req(32'h5000, 4'(FETCH_BURST_LEN));
    n = 0; t = 0;
    while (n < 4 && t < 50) begin
      @(negedge clk);
      t++;
      if (fetch_readdatavalid_o) n++;
    end
    check_eq("pre_reset_beats", n, 4);
    slave_hold = 1'b1;
    slave_flush = 1'b1;
    tick_in();
    reset = 1'b1;
    tick_in();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    check_eq("midrst_rdq_empty", rd_q.size(), 0);
    slave_hold = 1'b0;
    slave_flush = 1'b0;

    // After reset last_grant is writeback again: a tie goes to fetch.
    tick_in();
    cmd_q.push_back(mk_cmd(1'b0, 32'h6000, 4'(FETCH_BURST_LEN), 32'h0));
    cmd_q.push_back(mk_cmd(1'b1, 32'h6100, 4'd1, 32'h600D600D));
    fork
      begin
        fetch_req(32'h6000, 4'(FETCH_BURST_LEN));
        wait_beats(FETCH_BURST_LEN);
      end
      wb_req(32'h6100, 32'h600D600D);
    join

    repeat (3) @(negedge clk);
    check_eq("end_cmdq_empty", cmd_q.size(), 0);
    check_eq("end_rdq_empty", rd_q.size(), 0);
    check_eq("end_err_clear", err_unexp_rdv_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
